// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared constants and types for the video timing blocks.
//   - 720p60 default field lengths and pixel period
//   - region_e   : position of a counter inside its line/frame axis
//   - gen_state_e: run/drain/idle state of the sync generator
package video_timing_pkg;

   localparam int H_ACTIVE_720P      = 1280;
   localparam int H_SYNC_720P        = 40;
   localparam int H_BACK_PORCH_720P  = 220;
   localparam int H_FRONT_PORCH_720P = 110;
   localparam int V_ACTIVE_720P      = 720;
   localparam int V_SYNC_720P        = 5;
   localparam int V_BACK_PORCH_720P  = 20;
   localparam int V_FRONT_PORCH_720P = 5;
   localparam int PIX_PERIOD_PS_720P = 13468;
   localparam int CNT_W_DEFAULT      = 12;

   // Regions in the order they occur along an axis.
   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      BPORCH = 2'd1,
      ACTIVE = 2'd2,
      FPORCH = 2'd3
   } region_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } gen_state_e;

endpackage

// File: rtl/sync_axis_cnt.sv
// sync_axis_cnt
// One timing axis (horizontal or vertical): a wrapping position counter
// plus region/offset decode.
//   pix_clk, n_rst : clock, asynchronous active-low reset
//   clr_i          : force the counter to 0 (priority over inc_i)
//   inc_i          : advance the counter, wrapping after the last position
//   wrap_o         : current position is the last one of the axis
//   nxt_cnt_o      : position the counter takes at the coming edge
//   nxt_region_o   : region of that next position
//   nxt_offset_o   : next position relative to the first active position
// The decodes look at the next position so the parent can register its
// outputs on the same edge the counter moves, keeping them aligned.
module sync_axis_cnt
   import video_timing_pkg::*;
#(
   parameter int SYNC_LEN   = H_SYNC_720P,
   parameter int BPORCH_LEN = H_BACK_PORCH_720P,
   parameter int ACTIVE_LEN = H_ACTIVE_720P,
   parameter int FPORCH_LEN = H_FRONT_PORCH_720P,
   parameter int CNT_W      = CNT_W_DEFAULT
) (
   input  logic             pix_clk,
   input  logic             n_rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic             wrap_o,
   output logic [CNT_W-1:0] nxt_cnt_o,
   output region_e          nxt_region_o,
   output logic [CNT_W-1:0] nxt_offset_o
);

   localparam int TOTAL = SYNC_LEN + BPORCH_LEN + ACTIVE_LEN + FPORCH_LEN;
   localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC_LEN + BPORCH_LEN);
   // Region bounds carry one extra bit: the end of the active region may
   // equal 2^CNT_W when the front porch is empty.
   localparam logic [CNT_W:0] END_SYNC   = (CNT_W+1)'(SYNC_LEN);
   localparam logic [CNT_W:0] END_BPORCH = (CNT_W+1)'(SYNC_LEN + BPORCH_LEN);
   localparam logic [CNT_W:0] END_ACTIVE = (CNT_W+1)'(SYNC_LEN + BPORCH_LEN + ACTIVE_LEN);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W:0]   cnt_wide;

   assign wrap_o = (cnt_reg == LAST);

   always_comb begin
      cnt_next = cnt_reg;
      if (clr_i) begin
         cnt_next = '0;
      end else if (inc_i) begin
         cnt_next = wrap_o ? '0 : cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge pix_clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign cnt_wide = {1'b0, cnt_next};

   always_comb begin
      nxt_region_o = FPORCH;
      if (cnt_wide < END_SYNC) begin
         nxt_region_o = SYNC;
      end else if (cnt_wide < END_BPORCH) begin
         nxt_region_o = BPORCH;
      end else if (cnt_wide < END_ACTIVE) begin
         nxt_region_o = ACTIVE;
      end
   end

   assign nxt_cnt_o    = cnt_next;
   assign nxt_offset_o = cnt_next - ACT_START;

endmodule

// File: rtl/sync_gen.sv
// sync_gen
// Free-running video timing generator (transmit side of timing_gen).
//   pix_clk, n_rst : pixel clock, asynchronous active-low reset
//   en_i           : run request, level sensitive
//   hsync_o/vsync_o: active-high syncs (vsync spans whole lines)
//   de_o           : active-pixel enable
//   sof_o          : one-cycle pulse on the first cycle of each frame
//   x_o, y_o       : active pixel coordinates, 0 outside de_o
//   busy_o         : high from the first to the last cycle of generated frames
// Whole frames only: dropping en_i lets the current frame finish, and
// re-raising it before the end continues without a gap.
module sync_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE      = H_ACTIVE_720P,
   parameter int H_SYNC        = H_SYNC_720P,
   parameter int H_BACK_PORCH  = H_BACK_PORCH_720P,
   parameter int H_FRONT_PORCH = H_FRONT_PORCH_720P,
   parameter int V_ACTIVE      = V_ACTIVE_720P,
   parameter int V_SYNC        = V_SYNC_720P,
   parameter int V_BACK_PORCH  = V_BACK_PORCH_720P,
   parameter int V_FRONT_PORCH = V_FRONT_PORCH_720P,
   parameter int CNT_W         = CNT_W_DEFAULT
) (
   input  logic             pix_clk,
   input  logic             n_rst,
   input  logic             en_i,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             de_o,
   output logic             sof_o,
   output logic [CNT_W-1:0] x_o,
   output logic [CNT_W-1:0] y_o,
   output logic             busy_o
);

   localparam int H_TOTAL = H_ACTIVE + H_SYNC + H_BACK_PORCH + H_FRONT_PORCH;
   localparam int V_TOTAL = V_ACTIVE + V_SYNC + V_BACK_PORCH + V_FRONT_PORCH;

   generate
      if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_range_check
         $error("sync_gen: H_TOTAL or V_TOTAL does not fit in CNT_W bits");
      end
   endgenerate

   gen_state_e       state_reg, state_next;
   logic             en_reg;
   logic             h_wrap, v_wrap, frame_last, cnt_clr;
   logic [CNT_W-1:0] h_nxt, v_nxt, h_off, v_off;
   region_e          h_region, v_region;

   logic             hsync_next, vsync_next, de_next, sof_next, busy_next;
   logic [CNT_W-1:0] x_next, y_next;
   logic             hsync_reg, vsync_reg, de_reg, sof_reg, busy_reg;
   logic [CNT_W-1:0] x_reg, y_reg;

   // The FSM acts on a registered copy of en_i, so the first frame cycle
   // appears one edge after the edge that samples the request.
   assign frame_last = (state_reg != ST_IDLE) && h_wrap && v_wrap;

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (en_reg) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (frame_last)   state_next = en_reg ? ST_RUN : ST_IDLE;
            else if (!en_reg) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (frame_last)  state_next = en_reg ? ST_RUN : ST_IDLE;
            else if (en_reg) state_next = ST_RUN;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Counters sit at 0 while idle and on the start edge, so the first
   // active cycle is h=0, v=0.
   assign cnt_clr = (state_reg == ST_IDLE) || (state_next == ST_IDLE);

   sync_axis_cnt #(
      .SYNC_LEN(H_SYNC), .BPORCH_LEN(H_BACK_PORCH),
      .ACTIVE_LEN(H_ACTIVE), .FPORCH_LEN(H_FRONT_PORCH), .CNT_W(CNT_W)
   ) u_h_cnt (
      .pix_clk(pix_clk), .n_rst(n_rst), .clr_i(cnt_clr), .inc_i(1'b1),
      .wrap_o(h_wrap), .nxt_cnt_o(h_nxt), .nxt_region_o(h_region),
      .nxt_offset_o(h_off)
   );

   sync_axis_cnt #(
      .SYNC_LEN(V_SYNC), .BPORCH_LEN(V_BACK_PORCH),
      .ACTIVE_LEN(V_ACTIVE), .FPORCH_LEN(V_FRONT_PORCH), .CNT_W(CNT_W)
   ) u_v_cnt (
      .pix_clk(pix_clk), .n_rst(n_rst), .clr_i(cnt_clr), .inc_i(h_wrap),
      .wrap_o(v_wrap), .nxt_cnt_o(v_nxt), .nxt_region_o(v_region),
      .nxt_offset_o(v_off)
   );

   always_comb begin
      hsync_next = 1'b0;
      vsync_next = 1'b0;
      de_next    = 1'b0;
      sof_next   = 1'b0;
      busy_next  = 1'b0;
      x_next     = '0;
      y_next     = '0;
      if (state_next != ST_IDLE) begin
         busy_next  = 1'b1;
         hsync_next = (h_region == SYNC);
         vsync_next = (v_region == SYNC);
         de_next    = (h_region == ACTIVE) && (v_region == ACTIVE);
         sof_next   = (h_nxt == '0) && (v_nxt == '0);
         if (de_next) begin
            x_next = h_off;
            y_next = v_off;
         end
      end
   end

   always_ff @(posedge pix_clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg <= ST_IDLE;
         en_reg    <= 1'b0;
         hsync_reg <= 1'b0;
         vsync_reg <= 1'b0;
         de_reg    <= 1'b0;
         sof_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         x_reg     <= '0;
         y_reg     <= '0;
      end else begin
         state_reg <= state_next;
         en_reg    <= en_i;
         hsync_reg <= hsync_next;
         vsync_reg <= vsync_next;
         de_reg    <= de_next;
         sof_reg   <= sof_next;
         busy_reg  <= busy_next;
         x_reg     <= x_next;
         y_reg     <= y_next;
      end
   end

   assign hsync_o = hsync_reg;
   assign vsync_o = vsync_reg;
   assign de_o    = de_reg;
   assign sof_o   = sof_reg;
   assign busy_o  = busy_reg;
   assign x_o     = x_reg;
   assign y_o     = y_reg;

endmodule
